seg_scan_driver: RTL and testbench

Multiplexed 7-segment display driver for the stopwatch: the output-to-user counterpart of the push-button input conditioner. It holds a tear-free shadow copy of a packed BCD value and time-multiplexes it onto a common-anode display (active-low anodes and segments). Scanning includes an anti-ghosting blank gap, optional leading-zero blanking, and per-digit blinking. It sits between the stopwatch time/mode logic and the board display pins.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_decode.sv | 28 ++
 rtl/seg_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   bcd_t        : one packed BCD digit (4 bits)
//   SEG_*        : active-low segment codes, bit order {g,f,e,d,c,b,a}
package seg_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to active-low 7-segment decoder.
//   digit  : BCD digit; codes 10..15 render as a dash
//   seg_n  : segments {g,f,e,d,c,b,a}, active-low
module seg_decode
  import seg_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    unique case (digit)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver with tear-free frame updates,
// anti-ghosting blank gap, leading-zero blanking and per-digit blink.
//   clk, rst    : clock, synchronous active-high reset
//   value       : packed BCD, digit 0 (rightmost) in [3:0]
//   dp, blink   : per-digit decimal point / blink enable
//   lzb         : leading-zero blanking enable
//   load        : strobe capturing value/dp/blink for the next frame boundary
//   pending     : a captured load is waiting for the frame boundary
//   an_n        : active-low anodes, at most one low
//   seg_n, dp_n : active-low segments {g,f,e,d,c,b,a} and decimal point
//   frame_tick  : one-cycle pulse after each frame boundary
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lzb,
  input  logic                  load,
  output logic                  pending,
  output logic [DIGITS-1:0]     an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       fcnt;
  logic                phase;

  logic [4*DIGITS-1:0] shadow_val, pend_val;
  logic [DIGITS-1:0]   shadow_dp, pend_dp;
  logic [DIGITS-1:0]   shadow_blink, pend_blink;

  logic                wrap, last_slot, boundary;
  logic [DIGITS-1:0]   lz_mask;
  logic                zeros_above;
  bcd_t                cur_digit;
  logic                cur_dp, cur_blink, cur_lz;
  logic [6:0]          dec_seg;
  logic [DIGITS-1:0]   an_d;
  logic [6:0]          seg_d;
  logic                dp_d;

  assign wrap      = (cnt == CW'(PRESCALE - 1));
  assign last_slot = (idx == IW'(DIGITS - 1));
  assign boundary  = wrap && last_slot;

  // Digit k is a leading zero when it and every digit to its left are zero.
  always_comb begin
    lz_mask     = '0;
    zeros_above = 1'b1;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      zeros_above = zeros_above && (shadow_val[4*k +: 4] == 4'd0);
      lz_mask[k]  = zeros_above;
    end
  end

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_digit = shadow_val[4*k +: 4];
        cur_dp    = shadow_dp[k];
        cur_blink = shadow_blink[k];
        cur_lz    = lz_mask[k];
      end
    end
  end

  seg_decode u_dec (
    .digit (cur_digit),
    .seg_n (dec_seg)
  );

  always_comb begin
    an_d = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if ((cnt >= CW'(BLANK_CYC)) && (idx == IW'(k))) an_d[k] = 1'b0;
    end
    seg_d = dec_seg;
    dp_d  = ~cur_dp;
    if (phase && cur_blink) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end else if (lzb && cur_lz) begin
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      fcnt         <= '0;
      phase        <= 1'b0;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      shadow_blink <= '0;
      pend_val     <= '0;
      pend_dp      <= '0;
      pend_blink   <= '0;
      pending      <= 1'b0;
      an_n         <= '1;
      seg_n        <= SEG_BLANK;
      dp_n         <= 1'b1;
      frame_tick   <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= last_slot ? '0 : idx + 1'b1;

      if (boundary) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end

      // A load landing on the boundary bypasses the pending register.
      if (load && boundary) begin
        shadow_val   <= value;
        shadow_dp    <= dp;
        shadow_blink <= blink;
        pending      <= 1'b0;
      end else if (load) begin
        pend_val   <= value;
        pend_dp    <= dp;
        pend_blink <= blink;
        pending    <= 1'b1;
      end else if (boundary && pending) begin
        shadow_val   <= pend_val;
        shadow_dp    <= pend_dp;
        shadow_blink <= pend_blink;
        pending      <= 1'b0;
      end

      an_n       <= an_d;
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int D  = 4;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int BF = 2;
  localparam int FRAME = D * P;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   value = '0;
  logic [3:0]    dp = '0;
  logic [3:0]    blink = '0;
  logic          lzb = 1'b0;
  logic          load = 1'b0;
  logic          pending;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic          frame_tick;

  int errors = 0;
  int checks = 0;

  // Reference model state: cycles since reset plus shadow/pending content.
  int            t;
  logic [15:0]   m_sh_val, m_pd_val;
  logic [3:0]    m_sh_dp, m_pd_dp, m_sh_bl, m_pd_bl;
  logic          m_pending;
  logic [6:0]    segtab [16];

  seg_scan_driver #(
    .DIGITS       (D),
    .PRESCALE     (P),
    .BLANK_CYC    (B),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .blink      (blink),
    .lzb        (lzb),
    .load       (load),
    .pending    (pending),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic model_clear();
    t = 0;
    m_sh_val = '0; m_pd_val = '0;
    m_sh_dp = '0;  m_pd_dp = '0;
    m_sh_bl = '0;  m_pd_bl = '0;
    m_pending = 1'b0;
  endtask

  // One clock: predict outputs from the display rules, then compare #1 later.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_ft, ph, bnd, boff, lzq;
    int         c, s, f;
    logic [3:0] dig;
    @(posedge clk);
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
      model_clear();
    end else begin
      c   = t % P;
      s   = (t / P) % D;
      f   = t / FRAME;
      ph  = ((f / BF) % 2) == 1;
      bnd = (t % FRAME) == FRAME - 1;
      dig = 4'((m_sh_val >> (4 * s)) & 16'hF);
      boff = ph && m_sh_bl[s];
      lzq  = lzb && (s >= 1) && ((m_sh_val >> (4 * s)) == 16'd0);
      e_an  = (c >= B) ? ~(4'b0001 << s) : 4'hF;
      e_seg = (boff || lzq) ? 7'h7F : segtab[dig];
      e_dp  = boff ? 1'b1 : ~m_sh_dp[s];
      e_ft  = bnd;
      if (load && bnd) begin
        m_sh_val = value; m_sh_dp = dp; m_sh_bl = blink; m_pending = 1'b0;
      end else if (load) begin
        m_pd_val = value; m_pd_dp = dp; m_pd_bl = blink; m_pending = 1'b1;
      end else if (bnd && m_pending) begin
        m_sh_val = m_pd_val; m_sh_dp = m_pd_dp; m_sh_bl = m_pd_bl; m_pending = 1'b0;
      end
      t++;
    end
    #1;
    chk("an_n", 32'(an_n), 32'(e_an));
    chk("seg_n", 32'(seg_n), 32'(e_seg));
    chk("dp_n", 32'(dp_n), 32'(e_dp));
    chk("pending", 32'(pending), 32'(m_pending));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next edge will sample state with t%FRAME == pos.
  task automatic goto_pos(input int pos);
    for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blink = b; load = 1'b1;
    step();
    load = 1'b0;
    value = 16'($urandom);
    dp = 4'($urandom);
    blink = 4'($urandom);
  endtask

  initial begin
    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    model_clear();

    rst = 1'b1;
    run(3);
    rst = 1'b0;

    // Idle scan of all-zero shadow
    run(64);

    // Mid-frame load
    goto_pos(10);
    do_load(16'h1234, 4'b0000, 4'b0000);
    run(70);

    // Load on the boundary cycle: no pending pulse
    goto_pos(FRAME - 1);
    do_load(16'h0907, 4'b0000, 4'b0000);
    chk("boundary_load_no_pending", 32'(pending), 32'(0));
    run(70);

    // Leading-zero blanking
    lzb = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    run(70);
    lzb = 1'b0;

    // Blink digit 0 with its decimal point
    do_load(16'h0008, 4'b0001, 4'b0001);
    run(300);

    // Reset while a load of 9999 is pending: the 9s must never reach the pins
    goto_pos(5);
    do_load(16'h9999, 4'b1111, 4'b0000);
    run(4);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      checks++;
      assert (seg_n !== 7'h10) else begin
        errors++;
        $error("FAIL no_nine_after_reset: observed %h expected not 10", seg_n);
      end
    end

    // Randomized loads, including non-BCD codes and random lzb
    for (int n = 0; n < 25; n++) begin
      lzb = 1'($urandom);
      run(int'($urandom_range(0, 40)));
      do_load(16'($urandom), 4'($urandom), 4'($urandom));
    end
    run(150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
